// File: rtl/shift_deser_rx.sv
// shift_deser_rx: serial-in/parallel-out receiver, MSB- or LSB-first, with a
// one-entry valid/ready holding register and a sticky overrun flag.
module shift_deser_rx #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_a,
    input  logic                     sin,
    input  logic                     sin_vld,
    input  logic                     dir,
    input  logic                     clr,
    output logic [WIDTH-1:0]         op,
    output logic                     op_vld,
    input  logic                     op_rdy,
    output logic                     ovf,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_q, sreg_d, op_q, op_d, word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d, ovf_q, ovf_d;
    logic             cap, done, free;

    always_comb begin
        cap    = sin_vld && !clr;
        word   = dir ? {sin, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], sin};
        done   = cap && (cnt_q == CW'(WIDTH - 1));
        free   = !vld_q || op_rdy;
        sreg_d = clr ? '0 : cap ? word : sreg_q;
        cnt_d  = (clr || done) ? '0 : cap ? cnt_q + CW'(1) : cnt_q;
        op_d   = (done && free) ? word : op_q;
        // A load into a freed slot keeps valid high even when consumed this cycle
        vld_d  = (done && free) ? 1'b1 : (vld_q && op_rdy) ? 1'b0 : vld_q;
        ovf_d  = clr ? 1'b0 : (done && !free) ? 1'b1 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign op      = op_q;
    assign op_vld  = vld_q;
    assign ovf     = ovf_q;
    assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_shift_deser_rx.sv
// tb_shift_deser_rx: directed stimulus against an arithmetic receiver model,
// checked every cycle, plus literal expectations from hand-worked words.
module tb_shift_deser_rx;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_a = 1'b0, sin = 1'b0, sin_vld = 1'b0, dir = 1'b0, clr = 1'b0, op_rdy = 1'b0;
    logic [W-1:0] op;
    logic         op_vld, ovf;
    logic [2:0]   bit_cnt;

    int total = 0, bad = 0, rises = 0;
    bit run = 1'b0;
    logic prev_vld = 1'b0;
    int m_sh = 0, m_cnt = 0, m_op = 0;
    bit m_vld = 1'b0, m_ovf = 1'b0;

    shift_deser_rx #(.WIDTH(W)) dut (
        .clk(clk), .rst_a(rst_a), .sin(sin), .sin_vld(sin_vld), .dir(dir), .clr(clr),
        .op(op), .op_vld(op_vld), .op_rdy(op_rdy), .ovf(ovf), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Model: the received word as an integer, bit count as a plain counter
    always @(posedge clk) begin
        bit done, consume;
        if (rst_a) begin
            m_sh = 0; m_cnt = 0; m_op = 0; m_vld = 0; m_ovf = 0;
        end else begin
            done = 0;
            consume = m_vld && op_rdy;
            if (clr) begin
                m_sh = 0; m_cnt = 0; m_ovf = 0;
            end else if (sin_vld) begin
                m_sh = dir ? (m_sh / 2 + int'(sin) * (2 ** (W - 1))) : ((m_sh * 2 + int'(sin)) % (2 ** W));
                m_cnt++;
                if (m_cnt == W) begin m_cnt = 0; done = 1; end
            end
            if (done && (!m_vld || op_rdy)) begin
                m_op = m_sh; m_vld = 1;
            end else begin
                if (done) m_ovf = 1;
                if (consume) m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("op", 32'(op), 32'(m_op));
            chk("op_vld", 32'(op_vld), 32'(m_vld));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
            if (op_vld && !prev_vld) rises++;
            prev_vld = op_vld;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input logic d);
        sin = b; dir = d; sin_vld = 1'b1;
        tick();
        sin_vld = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic d, input int gmax, input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            if (rdy_last && i == W - 1) op_rdy = 1'b1;
            send_bit(d ? w[i] : w[W-1-i], d);
            op_rdy = 1'b0;
            repeat ($urandom_range(0, gmax)) tick();
        end
    endtask

    task automatic consume();
        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
    endtask

    initial begin
        logic [7:0] stream;
        stream = 8'b0001_1110;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        run = 1'b1;
        chk("rst_op", 32'(op), 0);
        chk("rst_vld", 32'(op_vld), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cnt", 32'(bit_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            send_bit(stream[7-i], 1'b0);
            chk("msb_cnt", 32'(bit_cnt), 32'((i + 1) % 8));
        end
        chk("msb_op", 32'(op), 32'h1E);
        chk("msb_vld", 32'(op_vld), 1);
        chk("msb_ovf", 32'(ovf), 0);
        consume();

        for (int i = 0; i < 8; i++) send_bit(stream[7-i], 1'b1);
        chk("lsb_op", 32'(op), 32'h78);
        chk("lsb_vld", 32'(op_vld), 1);
        consume();
        chk("lsb_cons_vld", 32'(op_vld), 0);
        chk("lsb_cons_op", 32'(op), 32'h78);

        send_word(8'h11, 1'b0, 0, 0);
        send_word(8'h22, 1'b0, 0, 0);
        chk("ovr_op", 32'(op), 32'h11);
        chk("ovr_vld", 32'(op_vld), 1);
        chk("ovr_ovf", 32'(ovf), 1);
        consume();
        chk("ovr_cons_vld", 32'(op_vld), 0);
        chk("ovr_keep_ovf", 32'(ovf), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);

        send_word(8'h11, 1'b0, 0, 0);
        chk("sim_pre_op", 32'(op), 32'h11);
        send_word(8'hC3, 1'b0, 0, 1);
        chk("sim_op", 32'(op), 32'hC3);
        chk("sim_vld", 32'(op_vld), 1);
        chk("sim_ovf", 32'(ovf), 0);
        consume();

        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clrmid_cnt", 32'(bit_cnt), 0);
        send_word(8'h5A, 1'b0, 0, 0);
        chk("clrmid_op", 32'(op), 32'h5A);
        consume();

        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        clr = 1'b1; sin = 1'b1; sin_vld = 1'b1;
        tick();
        clr = 1'b0; sin_vld = 1'b0;
        chk("clrstb_cnt", 32'(bit_cnt), 0);
        send_word(8'h3C, 1'b0, 0, 0);
        chk("clrstb_op", 32'(op), 32'h3C);
        consume();

        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
        chk("mixdir_vld", 32'(op_vld), 1);
        consume();

        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        chk("rstmid_op", 32'(op), 0);
        chk("rstmid_vld", 32'(op_vld), 0);
        chk("rstmid_ovf", 32'(ovf), 0);
        chk("rstmid_cnt", 32'(bit_cnt), 0);

        rises = 0;
        send_word(8'hA5, 1'b0, 3, 0);
        repeat (3) tick();
        chk("gap_op", 32'(op), 32'hA5);
        chk("gap_vld", 32'(op_vld), 1);
        chk("gap_rises", 32'(rises), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
